// File: rtl/medidor_distancia.sv
// medidor_distancia: ultrasonic range finder front-end.
//
// Fires the sensor trigger once per period and times the echo pulse into a
// 4-digit BCD counter (hundreds, tens, units, tenths of cm). The BCD word and a
// qualified echo window are handed to the display stage, which latches the word
// on the falling edge of echo_medicion.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous, active-high reset
//   echo                raw sensor echo, asynchronous to clk
//   trigger             sensor trigger pulse, TRIGGER_CICLOS wide every PERIODO_CICLOS
//   echo_medicion       qualified measurement window (high in MIDIENDO and ENTREGA)
//   distancia_calculada BCD result {hundreds, tens, units, tenths}
//   medicion_valida     one-cycle pulse when distancia_calculada is updated
//   fuera_rango         last result came from a timeout; held until the next result
module medidor_distancia #(
  parameter int unsigned TICKS_POR_MM   = 291,
  parameter int unsigned TRIGGER_CICLOS = 500,
  parameter int unsigned PERIODO_CICLOS = 3_000_000,
  parameter int unsigned TIMEOUT_CICLOS = 1_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        echo,
  output logic        trigger,
  output logic        echo_medicion,
  output logic [15:0] distancia_calculada,
  output logic        medicion_valida,
  output logic        fuera_rango
);

  typedef enum logic [2:0] {
    StReposo,
    StDisparo,
    StEsperaEco,
    StMidiendo,
    StEntrega
  } estado_t;

  localparam int unsigned PerW   = $clog2(PERIODO_CICLOS);
  localparam int unsigned TmrMax = (TRIGGER_CICLOS > TIMEOUT_CICLOS) ? TRIGGER_CICLOS
                                                                       : TIMEOUT_CICLOS;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam int unsigned PreW   = (TICKS_POR_MM > 1) ? $clog2(TICKS_POR_MM) : 1;

  localparam logic [PerW-1:0] PerLast  = PerW'(PERIODO_CICLOS - 1);
  localparam logic [TmrW-1:0] TrigLast = TmrW'(TRIGGER_CICLOS - 1);
  localparam logic [TmrW-1:0] TmoLast  = TmrW'(TIMEOUT_CICLOS - 1);
  localparam logic [PreW-1:0] PreLast  = PreW'(TICKS_POR_MM - 1);

  localparam logic [15:0] BcdMax = 16'h9999;

  // BCD +1 with digit carry; holds at 9999 instead of wrapping to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return (v == BcdMax) ? v : r;
  endfunction

  // Two-flop synchronizer; nothing below looks at the raw echo.
  logic echo_meta, echo_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
    end
  end

  estado_t         estado_q, estado_d;
  logic [PerW-1:0] per_q, per_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [PreW-1:0] pre_q, pre_d, pre_next;
  logic [15:0]     bcd_q, bcd_d, bcd_tick;
  logic [15:0]     dist_q, dist_d;
  logic            fr_q, fr_d;
  logic            valida_q, valida_d;
  logic            trigger_q, em_q;
  logic            pre_wrap;

  // One prescaler step. bcd_tick is the count including the current cycle, so
  // the cycle on which echo_s is seen low still contributes its tick; that makes
  // the counted interval equal the raw echo width.
  always_comb begin
    pre_wrap = (pre_q == PreLast);
    pre_next = pre_wrap ? '0 : pre_q + PreW'(1);
    bcd_tick = pre_wrap ? bcd_inc(bcd_q) : bcd_q;
  end

  always_comb begin
    estado_d = estado_q;
    pre_d    = pre_q;
    bcd_d    = bcd_q;
    dist_d   = dist_q;
    fr_d     = fr_q;
    valida_d = 1'b0;

    unique case (estado_q)
      StReposo: begin
        if (per_q == PerLast) begin
          estado_d = StDisparo;
        end
      end

      StDisparo: begin
        if (tmr_q == TrigLast) begin
          estado_d = StEsperaEco;
        end
      end

      StEsperaEco: begin
        // An echo already high on entry is taken as an immediate rising edge.
        if (echo_s) begin
          estado_d = StMidiendo;
          pre_d    = '0;
          bcd_d    = '0;
        end else if (tmr_q == TmoLast) begin
          estado_d = StEntrega;
          dist_d   = BcdMax;
          fr_d     = 1'b1;
          valida_d = 1'b1;
        end
      end

      StMidiendo: begin
        pre_d = pre_next;
        bcd_d = bcd_tick;
        if (!echo_s) begin
          // Partial prescaler count is dropped (truncation).
          estado_d = StEntrega;
          dist_d   = bcd_tick;
          fr_d     = 1'b0;
          valida_d = 1'b1;
        end else if (tmr_q == TmoLast) begin
          estado_d = StEntrega;
          dist_d   = BcdMax;
          fr_d     = 1'b1;
          valida_d = 1'b1;
        end
      end

      StEntrega: begin
        estado_d = StReposo;
      end

      default: begin
        estado_d = StReposo;
      end
    endcase
  end

  // Period counter runs every cycle and restarts on each trigger; the
  // period constraint guarantees it is back in REPOSO before it reaches the end.
  // The state timer restarts on every state change and idles in REPOSO.
  always_comb begin
    per_d = ((estado_d == StDisparo) && (estado_q != StDisparo)) ? '0 : per_q + PerW'(1);
    tmr_d = ((estado_d != estado_q) || (estado_q == StReposo)) ? '0 : tmr_q + TmrW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= StReposo;
      per_q     <= PerLast;
      tmr_q     <= '0;
      pre_q     <= '0;
      bcd_q     <= '0;
      dist_q    <= '0;
      fr_q      <= 1'b0;
      valida_q  <= 1'b0;
      trigger_q <= 1'b0;
      em_q      <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      per_q     <= per_d;
      tmr_q     <= tmr_d;
      pre_q     <= pre_d;
      bcd_q     <= bcd_d;
      dist_q    <= dist_d;
      fr_q      <= fr_d;
      valida_q  <= valida_d;
      // Outputs registered from the next state: same timing as a state decode,
      // but glitch-free toward the sensor and the display.
      trigger_q <= (estado_d == StDisparo);
      em_q      <= (estado_d == StMidiendo) || (estado_d == StEntrega);
    end
  end

  assign trigger             = trigger_q;
  assign echo_medicion       = em_q;
  assign distancia_calculada = dist_q;
  assign medicion_valida     = valida_q;
  assign fuera_rango         = fr_q;

endmodule

// File: tb/tb_medidor_distancia.sv
// Testbench for medidor_distancia. Two instances share clock, reset and echo:
// dut with TICKS_POR_MM=4 and dut1 with TICKS_POR_MM=1 (used for saturation).
// Expected results are pushed to a queue when an echo is driven and compared
// when the monitor captures a medicion_valida pulse.
module tb_medidor_distancia;

  localparam int unsigned TICKS = 4;
  localparam int unsigned TRIG  = 5;
  localparam int unsigned TMO   = 12000;
  localparam int unsigned PER   = 30000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        echo = 1'b0;
  logic        trigger, echo_medicion, medicion_valida, fuera_rango;
  logic [15:0] distancia_calculada;
  logic        trigger1, echo_medicion1, medicion_valida1, fuera_rango1;
  logic [15:0] distancia_calculada1;

  medidor_distancia #(
    .TICKS_POR_MM  (TICKS),
    .TRIGGER_CICLOS(TRIG),
    .PERIODO_CICLOS(PER),
    .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .echo               (echo),
    .trigger            (trigger),
    .echo_medicion      (echo_medicion),
    .distancia_calculada(distancia_calculada),
    .medicion_valida    (medicion_valida),
    .fuera_rango        (fuera_rango)
  );

  medidor_distancia #(
    .TICKS_POR_MM  (1),
    .TRIGGER_CICLOS(TRIG),
    .PERIODO_CICLOS(PER),
    .TIMEOUT_CICLOS(TMO)
  ) dut1 (
    .clk                (clk),
    .reset              (reset),
    .echo               (echo),
    .trigger            (trigger1),
    .echo_medicion      (echo_medicion1),
    .distancia_calculada(distancia_calculada1),
    .medicion_valida    (medicion_valida1),
    .fuera_rango        (fuera_rango1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        f;
    logic [15:0] d1;
    logic        f1;
    logic        em;
    longint      cyc;
  } res_t;

  res_t   exp_q[$];
  res_t   obs_q[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_rise = 0;
  logic   trig_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    trig_prev <= trigger;
    if (trigger && !trig_prev) last_rise <= cyc;
  end

  always @(negedge clk) begin
    if (medicion_valida) begin
      obs_q.push_back('{distancia_calculada, fuera_rango, distancia_calculada1, fuera_rango1,
                        echo_medicion, cyc});
    end
  end

  // Reference: floor count saturated at 9999, expressed as BCD digits.
  function automatic logic [15:0] bcd_of(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic test_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    echo  = 1'b0;
    #1;
    checks++;
    if ({trigger, echo_medicion, medicion_valida, fuera_rango, distancia_calculada} !== 20'h0)
    begin
      errors++;
      $display("FAIL %s outputs in reset: got %b_%b_%b_%b_%h expected all zero", name, trigger,
               echo_medicion, medicion_valida, fuera_rango, distancia_calculada);
    end
    checks++;
    if ({fuera_rango1, distancia_calculada1} !== 17'h0) begin
      errors++;
      $display("FAIL %s dut1 outputs in reset: got %b_%h expected zero", name, fuera_rango1,
               distancia_calculada1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One measurement: optionally wait out the trigger, drive an echo w cycles
  // wide (w=0: no echo), then compare the result taken from the scoreboard.
  task automatic run_echo(input string name, input int unsigned w, input bit wait_trig);
    res_t   e, o;
    bit     seen, ok, got;
    longint r;
    if (wait_trig) begin
      seen = 1'b0;
      ok   = 1'b0;
      for (int i = 0; i < int'(PER) + 20; i++) begin
        @(negedge clk);
        #1;
        if (trigger) seen = 1'b1;
        else if (seen) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s trigger_done: got no trigger fall expected one within %0d", name, PER);
      end
    end
    r = cyc;
    if (w == 0) begin
      e = '{16'h9999, 1'b1, 16'h9999, 1'b1, 1'b1, last_rise + TRIG + TMO};
    end else if (w > TMO) begin
      e = '{16'h9999, 1'b1, 16'h9999, 1'b1, 1'b1, r + TMO + 3};
    end else begin
      e = '{bcd_of(w / TICKS), 1'b0, bcd_of(w), 1'b0, 1'b1, r + w + 3};
    end
    exp_q.push_back(e);
    if (w > 0) echo = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= int'(w + TMO) + 50; i++) begin
      @(negedge clk);
      if (w > 0 && i == int'(w)) echo = 1'b0;
      if (w >= 3 && i == 2) begin
        checks++;
        if (echo_medicion !== 1'b0) begin
          errors++;
          $display("FAIL %s em_early: got %b expected 0", name, echo_medicion);
        end
      end
      if (w >= 3 && i == 3) begin
        checks++;
        if (echo_medicion !== 1'b1) begin
          errors++;
          $display("FAIL %s em_rise_latency: got %b expected 1", name, echo_medicion);
        end
      end
      #1;
      if (obs_q.size() > 0 && i >= int'(w)) begin
        got = 1'b1;
        break;
      end
    end
    echo = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s result_arrival: got none expected medicion_valida", name);
      return;
    end
    o = obs_q.pop_front();
    checks++;
    if (o.d !== e.d) begin
      errors++;
      $display("FAIL %s distancia: got %h expected %h", name, o.d, e.d);
    end
    checks++;
    if (o.f !== e.f) begin
      errors++;
      $display("FAIL %s fuera_rango: got %b expected %b", name, o.f, e.f);
    end
    checks++;
    if (o.d1 !== e.d1 || o.f1 !== e.f1) begin
      errors++;
      $display("FAIL %s dut1_result: got %h/%b expected %h/%b", name, o.d1, o.f1, e.d1, e.f1);
    end
    checks++;
    if (o.cyc !== e.cyc) begin
      errors++;
      $display("FAIL %s valid_cycle: got %0d expected %0d", name, o.cyc, e.cyc);
    end
    checks++;
    if (o.em !== 1'b1) begin
      errors++;
      $display("FAIL %s em_at_valid: got %b expected 1", name, o.em);
    end
    @(negedge clk);
    checks++;
    if (medicion_valida !== 1'b0 || echo_medicion !== 1'b0) begin
      errors++;
      $display("FAIL %s after_entrega: got valid=%b em=%b expected 0/0", name, medicion_valida,
               echo_medicion);
    end
  endtask

  task automatic test_trigger_and_no_echo();
    longint t0, rel;
    int     wcnt;
    bit     ok;
    test_reset("reset_initial");
    rel = cyc;
    #1;
    checks++;
    if (trigger !== 1'b0) begin
      errors++;
      $display("FAIL trigger_before_edge: got %b expected 0", trigger);
    end
    @(negedge clk);
    #1;
    checks++;
    if (trigger !== 1'b1 || last_rise !== rel + 1) begin
      errors++;
      $display("FAIL first_trigger: got %b at %0d expected 1 at %0d", trigger, last_rise, rel + 1);
    end
    t0 = last_rise;
    wcnt = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (trigger) wcnt++;
      else break;
    end
    checks++;
    if (wcnt != int'(TRIG)) begin
      errors++;
      $display("FAIL trigger_width: got %0d expected %0d", wcnt, TRIG);
    end
    repeat (6000) @(negedge clk);
    checks++;
    if ({echo_medicion, medicion_valida, fuera_rango, distancia_calculada} !== 19'h0) begin
      errors++;
      $display("FAIL idle_outputs: got %b_%b_%b_%h expected all zero", echo_medicion,
               medicion_valida, fuera_rango, distancia_calculada);
    end
    run_echo("no_echo", 0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < int'(PER); i++) begin
      @(negedge clk);
      #1;
      if (trigger) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || last_rise - t0 != longint'(PER)) begin
      errors++;
      $display("FAIL trigger_period: got %0d expected %0d", last_rise - t0, PER);
    end
    run_echo("nominal_clears_fuera", 40, 1'b1);
  endtask

  task automatic test_bcd_carry();
    test_reset("reset_after_nominal");
    run_echo("carry_4003", 4003, 1'b1);
    test_reset("reset_carry");
    run_echo("carry_399", 399, 1'b1);
  endtask

  task automatic test_saturation();
    test_reset("reset_sat");
    run_echo("sat_10005", 10005, 1'b1);
  endtask

  task automatic test_timeout_echo();
    test_reset("reset_timeout");
    run_echo("long_echo", 12100, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen, ok;
    test_reset("reset_after_timeout");
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (trigger) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    echo = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || echo_medicion !== 1'b1) begin
      errors++;
      $display("FAIL mid_measuring: got em=%b expected 1", echo_medicion);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({trigger, echo_medicion, medicion_valida, fuera_rango, distancia_calculada} !== 20'h0)
    begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b_%b_%b_%b_%h expected all zero", trigger,
               echo_medicion, medicion_valida, fuera_rango, distancia_calculada);
    end
    echo = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_echo("after_mid_reset", 40, 1'b1);
  endtask

  initial begin
    test_trigger_and_no_echo();
    test_bcd_carry();
    test_saturation();
    test_timeout_echo();
    test_reset_mid();
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_results: got obs=%0d exp=%0d expected 0/0", obs_q.size(),
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
